// File: rtl/serial_word_loader.sv
// -----------------------------------------------------------------------------
// serial_word_loader
//
// Purpose:
//   Receives a framed serial word MSB-first, checks a trailing even-parity bit
//   and, when the parity matches, presents the word on a registered output
//   together with a one-cycle load strobe for a downstream latch.
//
//   Frame on the wire:
//     frame_start strobe (no payload) -> WIDTH payload bits -> 1 parity bit
//   Only cycles with sdata_valid=1 carry bits; gaps of any length are allowed.
//   The parity bit must equal the XOR of the WIDTH payload bits.
//
// Ports:
//   clk          in   single clock, all state updates on its rising edge
//   rst_n        in   asynchronous active-low reset
//   frame_start  in   one-cycle strobe opening (or restarting) a frame
//   sdata        in   serial bit, sampled only when sdata_valid=1
//   sdata_valid  in   qualifier for sdata
//   abort        in   synchronous cancel; highest priority of all inputs
//   data         out  last successfully received word (registered)
//   load         out  one-cycle strobe: data is new and valid
//   busy         out  high whenever the FSM is not IDLE
//   err          out  one-cycle strobe: parity mismatch or frame restart
//   dbg_state    out  current FSM state, for observation only
//
// Handshake:
//   There is no back-pressure. A bit is consumed on every rising edge where
//   sdata_valid=1 and the FSM is collecting payload or parity. load is high
//   for exactly the one cycle after the parity-bit sample edge, and data
//   already holds the new word in that cycle. load and err are mutually
//   exclusive.
// -----------------------------------------------------------------------------
module serial_word_loader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             sdata,
    input  logic             sdata_valid,
    input  logic             abort,
    output logic [WIDTH-1:0] data,
    output logic             load,
    output logic             busy,
    output logic             err,
    output logic [1:0]       dbg_state
);

    // Counter only needs to reach WIDTH-1: the bit received while it holds
    // WIDTH-1 is the last payload bit.
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_LOAD   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   sh_q,    sh_d;
    logic [WIDTH-1:0]   data_q,  data_d;
    logic               err_q,   err_d;

    logic               parity_exp;

    // Even parity over the complete payload; sh_q is full while in PARITY.
    assign parity_exp = ^sh_q;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        data_d  = data_q;
        err_d   = 1'b0;

        if (abort) begin
            // Abort outranks frame_start and sdata_valid. From LOAD this is
            // the normal exit anyway, so the load pulse already showing is
            // unaffected. Counter and shift register are left as they are:
            // they are cleared by the next frame_start before being used.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // sdata_valid in the opening cycle carries no payload.
                    if (frame_start) begin
                        state_d = S_SHIFT;
                        cnt_d   = '0;
                        sh_d    = '0;
                    end
                end

                S_SHIFT: begin
                    if (frame_start) begin
                        // Restart: drop the partial word and flag it.
                        state_d = S_SHIFT;
                        cnt_d   = '0;
                        sh_d    = '0;
                        err_d   = 1'b1;
                    end else if (sdata_valid) begin
                        sh_d  = {sh_q[WIDTH-2:0], sdata};
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BIT) begin
                            state_d = S_PARITY;
                        end
                    end
                end

                S_PARITY: begin
                    if (frame_start) begin
                        state_d = S_SHIFT;
                        cnt_d   = '0;
                        sh_d    = '0;
                        err_d   = 1'b1;
                    end else if (sdata_valid) begin
                        if (sdata == parity_exp) begin
                            // Capture on the sample edge so data is already
                            // valid in the cycle load is high.
                            state_d = S_LOAD;
                            data_d  = sh_q;
                        end else begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    // One cycle only; a frame_start seen here is dropped.
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // load and busy decode the state register directly, so both clear
    // asynchronously with rst_n alongside the registered err and data.
    assign data      = data_q;
    assign load      = (state_q == S_LOAD);
    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign dbg_state = state_q;

    // -------------------------------------------------------------------------
    // Embedded properties
    // -------------------------------------------------------------------------
    a_load_err_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(load && err));

    a_load_one_cycle: assert property (@(posedge clk) disable iff (!rst_n)
        load |=> !load);

    a_err_one_cycle_idle: assert property (@(posedge clk) disable iff (!rst_n)
        (err && !busy) |=> !err);

endmodule

// File: doc/serial_word_loader.md
SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the number of payload bits per frame; the legal range is WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-004 The block SHALL have port frame_start, input, 1 bit: a one-cycle strobe that opens a frame; it carries no payload bit.
REQ-005 The block SHALL have port sdata, input, 1 bit: the serial bit, sampled only when sdata_valid=1.
REQ-006 The block SHALL have port sdata_valid, input, 1 bit: qualifies sdata; gaps of any length are allowed.
REQ-007 The block SHALL have port abort, input, 1 bit: synchronous cancel of any frame in progress.
REQ-008 The block SHALL have port data, output, WIDTH bits: the last successfully received word, registered.
REQ-009 The block SHALL have port load, output, 1 bit: a one-cycle strobe meaning data is new and valid; it drives the downstream latch load.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-011 The block SHALL have port err, output, 1 bit: a one-cycle strobe for a parity mismatch or a frame restart.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, SHIFT, PARITY and LOAD.
REQ-013 In IDLE, frame_start=1 SHALL move the FSM to SHIFT, clear the bit counter to 0 and clear the shift register; sdata_valid in that same cycle SHALL be ignored.
REQ-014 In SHIFT, each cycle with sdata_valid=1 SHALL shift MSB-first (sh <= {sh[WIDTH-2:0], sdata}) and increment the counter.
REQ-015 In SHIFT, the valid bit received while the counter = WIDTH-1 SHALL move the FSM to PARITY.
REQ-016 Cycles in SHIFT with sdata_valid=0 SHALL hold the shift register, counter and state.
REQ-017 In PARITY, the first sdata_valid=1 SHALL sample the parity bit; the expected value is even parity, i.e. XOR of all WIDTH payload bits.
REQ-018 On a parity match, the FSM SHALL go to LOAD and capture data <= sh on the same edge.
REQ-019 On a parity mismatch, the FSM SHALL assert err for exactly 1 cycle (the next cycle), return to IDLE and leave data unchanged.
REQ-020 In LOAD, load SHALL be 1 for exactly one cycle and the FSM SHALL then return to IDLE unconditionally.
REQ-021 Latency from the parity-bit sample edge to load high SHALL be exactly 1 cycle, with data already holding the new word in that cycle.
REQ-022 data SHALL hold its value between successful frames and SHALL never change except on a parity match.
REQ-023 frame_start=1 while in SHIFT or PARITY SHALL restart the frame (SHIFT, counter 0, shift register cleared) and pulse err for 1 cycle.
REQ-024 frame_start=1 while in LOAD SHALL be ignored; load still completes and the FSM returns to IDLE.
REQ-025 abort=1 in any state SHALL force IDLE on the next edge, with no load and no err pulse, and SHALL take priority over frame_start and sdata_valid in the same cycle.
REQ-026 abort=1 while in LOAD SHALL still let the load pulse already in progress complete (LOAD exits to IDLE anyway).
REQ-027 busy SHALL be 1 in SHIFT, PARITY and LOAD, and 0 in IDLE.
REQ-028 load and err SHALL never be high in the same cycle.

Reset
REQ-029 rst_n=0 SHALL, asynchronously, set the state to IDLE, the counter and shift register to 0, data to 0, and load, err and busy to 0.
REQ-030 Assertion of rst_n=0 mid-frame SHALL discard the partial frame with no load or err.
REQ-031 After rst_n deasserts, the block SHALL accept a frame_start on the first clock edge.

Verification (WIDTH=8)
REQ-032 The bench SHALL cover: frame_start, then bits 1,0,1,0,0,1,0,1 back-to-back, then parity 0 -> load=1 one cycle after the parity bit, data=0xA5, err=0.
REQ-033 The bench SHALL cover: the same frame with parity 1 -> err=1 for one cycle, load=0, data keeps its previous value (0xA5 from the prior test, or 0x00 after reset).
REQ-034 The bench SHALL cover: frame 0xFF (parity 0) with sdata_valid low for 3 cycles between bits 4 and 5 -> load pulse, data=0xFF, busy high throughout.
REQ-035 The bench SHALL cover: frame_start again after 5 bits, then a full 0x3C frame with parity 0 -> one err pulse at the restart, then load with data=0x3C.
REQ-036 The bench SHALL cover: abort and frame_start together after 3 bits -> IDLE and busy=0 next cycle, no load, no err.
REQ-037 The bench SHALL cover: rst_n low for 2 cycles after 6 bits -> all outputs 0 immediately, with no pulse after release.
